mult_div_unit: RTL



---
 rtl/mult_div_unit.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/mult_div_unit.sv
// Sequential signed multiply/divide unit: radix-2 Booth multiply and restoring divide,
// 33-cycle latency, HI/LO result registers and a one-cycle divide-by-zero flag.
module mult_div_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic        start_mult,
  input  logic        start_div,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  output logic [31:0] hi_out,
  output logic [31:0] lo_out,
  output logic        busy,
  output logic        done,
  output logic        div_zero
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_MULT,
    S_DIV,
    S_FINISH,
    S_DIVZ
  } state_t;

  state_t      r_state;
  state_t      w_next_state;

  logic [5:0]  r_count;
  logic        r_is_div;

  // Booth product register: {acc[31:0], multiplier[31:0], q-1}
  logic [64:0] r_prod;
  logic [31:0] r_mcand;

  logic [31:0] r_rem;
  logic [31:0] r_quo;
  logic [31:0] r_dvsr;
  logic        r_sign_q;
  logic        r_sign_r;

  logic [31:0] r_hi;
  logic [31:0] r_lo;
  logic        r_done;
  logic        r_div_zero;

  logic        w_last;
  logic [32:0] w_acc_ext;
  logic [32:0] w_mcand_ext;
  logic [32:0] w_booth_sum;
  logic [64:0] w_prod_next;
  logic [32:0] w_div_shift;
  logic        w_div_ge;
  logic [31:0] w_div_diff;
  logic [31:0] w_abs_a;
  logic [31:0] w_abs_b;

  assign w_last = (r_count == 6'd1);

  // The accumulator is widened to 33 bits so that subtracting a -2^31 multiplicand
  // cannot overflow before the arithmetic shift brings it back into 32 bits.
  assign w_acc_ext   = {r_prod[64], r_prod[64:33]};
  assign w_mcand_ext = {r_mcand[31], r_mcand};

  // NOTE: every signal written in always_comb gets a default first, so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    w_booth_sum = w_acc_ext;
    case (r_prod[1:0])
      2'b01:   w_booth_sum = w_acc_ext + w_mcand_ext;
      2'b10:   w_booth_sum = w_acc_ext - w_mcand_ext;
      default: w_booth_sum = w_acc_ext;
    endcase
  end

  assign w_prod_next = {w_booth_sum, r_prod[32:1]};

  // Remainder stays below the divisor (<= 2^31), so the shifted pair fits in 33 bits
  // and a successful trial difference fits in 32.
  assign w_div_shift = {r_rem, r_quo[31]};
  assign w_div_ge    = (w_div_shift >= {1'b0, r_dvsr});
  assign w_div_diff  = w_div_shift[31:0] - r_dvsr;

  assign w_abs_a = op_a[31] ? (32'd0 - op_a) : op_a;
  assign w_abs_b = op_b[31] ? (32'd0 - op_b) : op_b;

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: begin
        if (start_mult)
          w_next_state = S_MULT;
        else if (start_div)
          w_next_state = (op_b == 32'd0) ? S_DIVZ : S_DIV;
      end
      S_MULT:   if (w_last) w_next_state = S_FINISH;
      S_DIV:    if (w_last) w_next_state = S_FINISH;
      S_FINISH: w_next_state = S_IDLE;
      S_DIVZ:   w_next_state = S_IDLE;
      default:  w_next_state = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register sees
  // the values from before the edge, independent of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      r_state <= S_IDLE;
    else
      r_state <= w_next_state;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count    <= 6'd0;
      r_is_div   <= 1'b0;
      r_prod     <= 65'd0;
      r_mcand    <= 32'd0;
      r_rem      <= 32'd0;
      r_quo      <= 32'd0;
      r_dvsr     <= 32'd0;
      r_sign_q   <= 1'b0;
      r_sign_r   <= 1'b0;
      r_hi       <= 32'd0;
      r_lo       <= 32'd0;
      r_done     <= 1'b0;
      r_div_zero <= 1'b0;
    end else begin
      r_done     <= 1'b0;
      r_div_zero <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start_mult) begin
            r_count  <= 6'd32;
            r_is_div <= 1'b0;
            r_prod   <= {32'd0, op_a, 1'b0};
            r_mcand  <= op_b;
          end else if (start_div) begin
            r_count  <= 6'd32;
            r_is_div <= 1'b1;
            r_rem    <= 32'd0;
            r_quo    <= w_abs_a;
            r_dvsr   <= w_abs_b;
            r_sign_q <= op_a[31] ^ op_b[31];
            r_sign_r <= op_a[31];
          end
        end
        S_MULT: begin
          r_prod  <= w_prod_next;
          r_count <= r_count - 6'd1;
        end
        S_DIV: begin
          if (w_div_ge) begin
            r_rem <= w_div_diff;
            r_quo <= {r_quo[30:0], 1'b1};
          end else begin
            r_rem <= w_div_shift[31:0];
            r_quo <= {r_quo[30:0], 1'b0};
          end
          r_count <= r_count - 6'd1;
        end
        S_FINISH: begin
          if (r_is_div) begin
            r_lo <= r_sign_q ? (32'd0 - r_quo) : r_quo;
            r_hi <= r_sign_r ? (32'd0 - r_rem) : r_rem;
          end else begin
            r_hi <= r_prod[64:33];
            r_lo <= r_prod[32:1];
          end
          r_done <= 1'b1;
        end
        S_DIVZ: begin
          r_done     <= 1'b1;
          r_div_zero <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign busy     = (r_state != S_IDLE);
  assign hi_out   = r_hi;
  assign lo_out   = r_lo;
  assign done     = r_done;
  assign div_zero = r_div_zero;

endmodule
